// File: rtl/attitude_angle_sched.sv
// rtl/attitude_angle_sched.sv - shares one cordic_angle unit between pitch and roll jobs per accel sample
// One active sample plus a single-entry pending slot; hung CORDIC jobs are aborted by a per-job timeout.
module attitude_angle_sched #(
  parameter int W              = 16,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int DROP_W         = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sample_valid,
  input  logic signed [W-1:0] ax,
  input  logic signed [W-1:0] ay,
  input  logic signed [W-1:0] az,
  output logic signed [W-1:0] cdra_x,
  output logic signed [W-1:0] cdra_y,
  output logic signed [W-1:0] cdra_z,
  output logic                cdra_start,
  input  logic                cdra_done,
  input  logic signed [W-1:0] crda_angle,
  output logic signed [W-1:0] pitch,
  output logic signed [W-1:0] roll,
  output logic                angle_valid,
  output logic                busy,
  output logic                err_timeout,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_P_START, S_P_WAIT, S_R_START, S_R_WAIT, S_PUBLISH
  } state_t;

  state_t                state_q, state_d;
  logic signed [W-1:0]   act_x_q, act_y_q, act_z_q;
  logic signed [W-1:0]   act_x_d, act_y_d, act_z_d;
  logic signed [W-1:0]   pend_x_q, pend_y_q, pend_z_q;
  logic signed [W-1:0]   pend_x_d, pend_y_d, pend_z_d;
  logic                  pend_full_q, pend_full_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic signed [W-1:0]   pitch_tmp_q, pitch_tmp_d;
  logic signed [W-1:0]   roll_tmp_q, roll_tmp_d;
  logic signed [W-1:0]   pitch_q, pitch_d;
  logic signed [W-1:0]   roll_q, roll_d;
  logic                  valid_q, valid_d;
  logic                  err_q, err_d;
  logic [DROP_W-1:0]     drop_q, drop_d;
  logic                  roll_job;

  always_comb begin
    state_d     = state_q;
    act_x_d     = act_x_q;
    act_y_d     = act_y_q;
    act_z_d     = act_z_q;
    pend_x_d    = pend_x_q;
    pend_y_d    = pend_y_q;
    pend_z_d    = pend_z_q;
    pend_full_d = pend_full_q;
    tmo_d       = tmo_q;
    pitch_tmp_d = pitch_tmp_q;
    roll_tmp_d  = roll_tmp_q;
    pitch_d     = pitch_q;
    roll_d      = roll_q;
    drop_d      = drop_q;
    valid_d     = 1'b0;
    err_d       = 1'b0;
    cdra_start  = 1'b0;

    case (state_q)
      S_IDLE: begin
        // The buffered sample is older, so it is served first and a new arrival refills the slot.
        if (pend_full_q) begin
          act_x_d     = pend_x_q;
          act_y_d     = pend_y_q;
          act_z_d     = pend_z_q;
          pend_full_d = sample_valid;
          if (sample_valid) begin
            pend_x_d = ax;
            pend_y_d = ay;
            pend_z_d = az;
          end
          state_d = S_P_START;
        end else if (sample_valid) begin
          act_x_d = ax;
          act_y_d = ay;
          act_z_d = az;
          state_d = S_P_START;
        end
      end
      S_P_START: begin
        cdra_start = 1'b1;
        tmo_d      = '0;
        state_d    = S_P_WAIT;
      end
      S_P_WAIT: begin
        if (cdra_done) begin
          pitch_tmp_d = crda_angle;
          state_d     = S_R_START;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_R_START: begin
        cdra_start = 1'b1;
        tmo_d      = '0;
        state_d    = S_R_WAIT;
      end
      S_R_WAIT: begin
        if (cdra_done) begin
          roll_tmp_d = crda_angle;
          state_d    = S_PUBLISH;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          tmo_d   = '0;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_PUBLISH: begin
        pitch_d = pitch_tmp_q;
        roll_d  = roll_tmp_q;
        valid_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && sample_valid) begin
      pend_x_d    = ax;
      pend_y_d    = ay;
      pend_z_d    = az;
      pend_full_d = 1'b1;
      if (pend_full_q && drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      act_x_q     <= '0;
      act_y_q     <= '0;
      act_z_q     <= '0;
      pend_x_q    <= '0;
      pend_y_q    <= '0;
      pend_z_q    <= '0;
      pend_full_q <= 1'b0;
      tmo_q       <= '0;
      pitch_tmp_q <= '0;
      roll_tmp_q  <= '0;
      pitch_q     <= '0;
      roll_q      <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      act_x_q     <= act_x_d;
      act_y_q     <= act_y_d;
      act_z_q     <= act_z_d;
      pend_x_q    <= pend_x_d;
      pend_y_q    <= pend_y_d;
      pend_z_q    <= pend_z_d;
      pend_full_q <= pend_full_d;
      tmo_q       <= tmo_d;
      pitch_tmp_q <= pitch_tmp_d;
      roll_tmp_q  <= roll_tmp_d;
      pitch_q     <= pitch_d;
      roll_q      <= roll_d;
      valid_q     <= valid_d;
      err_q       <= err_d;
      drop_q      <= drop_d;
    end
  end

  // Roll reuses the pitch datapath with x and y swapped.
  assign roll_job    = (state_q == S_R_START) || (state_q == S_R_WAIT);
  assign cdra_x      = roll_job ? act_y_q : act_x_q;
  assign cdra_y      = roll_job ? act_x_q : act_y_q;
  assign cdra_z      = act_z_q;
  assign pitch       = pitch_q;
  assign roll        = roll_q;
  assign angle_valid = valid_q;
  assign err_timeout = err_q;
  assign drop_cnt    = drop_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_attitude_angle_sched.sv
// tb/tb_attitude_angle_sched.sv - directed table-driven bench for attitude_angle_sched
// A negedge-driven CORDIC stub logs operands per start and answers after a programmed latency.
module tb_attitude_angle_sched;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               sample_valid;
  logic signed [15:0] ax, ay, az;
  logic signed [15:0] cdra_x, cdra_y, cdra_z;
  logic               cdra_start;
  logic               cdra_done = 1'b0;
  logic signed [15:0] crda_angle = '0;
  logic signed [15:0] pitch, roll;
  logic               angle_valid, busy, err_timeout;
  logic [7:0]         drop_cnt;

  attitude_angle_sched #(.W(16), .TIMEOUT_CYCLES(255), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .sample_valid(sample_valid),
    .ax(ax), .ay(ay), .az(az),
    .cdra_x(cdra_x), .cdra_y(cdra_y), .cdra_z(cdra_z),
    .cdra_start(cdra_start), .cdra_done(cdra_done), .crda_angle(crda_angle),
    .pitch(pitch), .roll(roll), .angle_valid(angle_valid), .busy(busy),
    .err_timeout(err_timeout), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int                 checks = 0;
  int                 errors = 0;
  int                 n_start = 0;
  int                 n_valid = 0;
  int                 n_err = 0;
  int                 job_base = 0;
  int                 stub_hang = 0;
  int                 lat_tab [2];
  logic signed [15:0] res_tab [4];
  logic signed [15:0] lx [64];
  logic signed [15:0] ly [64];
  logic signed [15:0] lz [64];
  int                 cnt = 0;
  logic signed [15:0] cur_res = '0;

  always @(negedge clk) begin
    int k;
    cdra_done = 1'b0;
    if (cnt > 0) begin
      cnt = cnt - 1;
      if (cnt == 0) begin
        cdra_done  = 1'b1;
        crda_angle = cur_res;
      end
    end
    if (cdra_start) begin
      k = n_start - job_base;
      lx[n_start & 63] = cdra_x;
      ly[n_start & 63] = cdra_y;
      lz[n_start & 63] = cdra_z;
      if (stub_hang == 0) begin
        cnt     = lat_tab[k & 1];
        cur_res = res_tab[k & 3];
      end
      n_start = n_start + 1;
    end
    if (angle_valid) n_valid = n_valid + 1;
    if (err_timeout) n_err = n_err + 1;
  end

  typedef struct {
    logic signed [15:0] ax, ay, az;
    int                 lat_p, lat_r;
    logic signed [15:0] res_p, res_r;
    int                 e_px, e_py, e_pz, e_rx, e_ry, e_rz;
    int                 e_lat;
  } vec_t;

  vec_t vt [4];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic nstep();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input int a, input int b, input int c);
    sample_valid = 1'b1;
    ax = 16'(a);
    ay = 16'(b);
    az = 16'(c);
    nstep();
    sample_valid = 1'b0;
  endtask

  task automatic wait_for(input int sel, input int lim, output int ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      if ((sel == 0 && angle_valid) || (sel == 1 && err_timeout)) begin
        ok = 1;
        break;
      end
      nstep();
    end
  endtask

  int t0, ok, v0, e0, s0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{16'sd10000, 16'sd10000, 16'sd11585, 20, 20, 16'sd1234, -16'sd567,
              10000, 10000, 11585, 10000, 10000, 11585, 43};
    vt[1] = '{16'sd8192, -16'sd4096, 16'sd16384, 5, 7, 16'sd100, -16'sd200,
              8192, -4096, 16384, -4096, 8192, 16384, 15};
    vt[2] = '{-16'sd32768, 16'sd32767, -16'sd1, 1, 1, 16'sd32767, -16'sd32768,
              -32768, 32767, -1, 32767, -32768, -1, 5};
    vt[3] = '{16'sd0, 16'sd0, 16'sd0, 3, 2, 16'sd0, 16'sd1,
              0, 0, 0, 0, 0, 0, 8};

    rst_n = 1'b0;
    sample_valid = 1'b0;
    ax = '0; ay = '0; az = '0;
    lat_tab[0] = 1; lat_tab[1] = 1;
    for (int i = 0; i < 4; i++) res_tab[i] = '0;
    nstep();
    nstep();
    chk("rst_pitch", pitch, 0);
    chk("rst_roll", roll, 0);
    chk("rst_valid", angle_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", cdra_start, 0);
    chk("rst_err", err_timeout, 0);
    chk("rst_drop", drop_cnt, 0);
    rst_n = 1'b1;
    nstep();
    chk("idle_busy", busy, 0);

    for (int v = 0; v < 4; v++) begin
      job_base   = n_start;
      v0         = n_valid;
      lat_tab[0] = vt[v].lat_p;
      lat_tab[1] = vt[v].lat_r;
      res_tab[0] = vt[v].res_p;
      res_tab[1] = vt[v].res_r;
      send(vt[v].ax, vt[v].ay, vt[v].az);
      t0 = cyc;
      wait_for(0, 200, ok);
      chk($sformatf("v%0d_valid_seen", v), ok, 1);
      chk($sformatf("v%0d_latency", v), cyc - t0, vt[v].e_lat);
      chk($sformatf("v%0d_pitch", v), pitch, int'(vt[v].res_p));
      chk($sformatf("v%0d_roll", v), roll, int'(vt[v].res_r));
      nstep();
      chk($sformatf("v%0d_valid_pulse", v), n_valid - v0, 1);
      chk($sformatf("v%0d_busy", v), busy, 0);
      chk($sformatf("v%0d_starts", v), n_start - job_base, 2);
      chk($sformatf("v%0d_px", v), lx[job_base & 63], vt[v].e_px);
      chk($sformatf("v%0d_py", v), ly[job_base & 63], vt[v].e_py);
      chk($sformatf("v%0d_pz", v), lz[job_base & 63], vt[v].e_pz);
      chk($sformatf("v%0d_rx", v), lx[(job_base + 1) & 63], vt[v].e_rx);
      chk($sformatf("v%0d_ry", v), ly[(job_base + 1) & 63], vt[v].e_ry);
      chk($sformatf("v%0d_rz", v), lz[(job_base + 1) & 63], vt[v].e_rz);
    end

    // three samples during one job: the second is overwritten by the third
    job_base = n_start;
    v0 = n_valid;
    lat_tab[0] = 10; lat_tab[1] = 10;
    res_tab[0] = 16'sd11; res_tab[1] = 16'sd22; res_tab[2] = 16'sd33; res_tab[3] = 16'sd44;
    sample_valid = 1'b1;
    ax = 16'sd1; ay = 16'sd2; az = 16'sd3;
    nstep();
    ax = 16'sd4; ay = 16'sd5; az = 16'sd6;
    nstep();
    ax = 16'sd7; ay = 16'sd8; az = 16'sd9;
    nstep();
    sample_valid = 1'b0;
    chk("ovr_drop", drop_cnt, 1);
    wait_for(0, 200, ok);
    chk("ovr_first_seen", ok, 1);
    chk("ovr_first_pitch", pitch, 11);
    chk("ovr_first_roll", roll, 22);
    nstep();
    wait_for(0, 200, ok);
    chk("ovr_second_seen", ok, 1);
    chk("ovr_second_pitch", pitch, 33);
    chk("ovr_second_roll", roll, 44);
    nstep();
    chk("ovr_valids", n_valid - v0, 2);
    chk("ovr_starts", n_start - job_base, 4);
    chk("ovr_p2x", lx[(job_base + 2) & 63], 7);
    chk("ovr_p2y", ly[(job_base + 2) & 63], 8);
    chk("ovr_r2x", lx[(job_base + 3) & 63], 8);
    chk("ovr_r2y", ly[(job_base + 3) & 63], 7);
    chk("ovr_r2z", lz[(job_base + 3) & 63], 9);

    // hung CORDIC: abort after the timeout, angles untouched
    stub_hang = 1;
    job_base = n_start;
    v0 = n_valid;
    e0 = n_err;
    send(100, 200, 300);
    t0 = cyc;
    wait_for(1, 400, ok);
    chk("tmo_seen", ok, 1);
    chk("tmo_cycle", cyc - t0, 256);
    nstep();
    chk("tmo_pulse", n_err - e0, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_pitch", pitch, 33);
    chk("tmo_roll", roll, 44);
    chk("tmo_no_valid", n_valid - v0, 0);
    chk("tmo_starts", n_start - job_base, 1);
    stub_hang = 0;
    job_base = n_start;
    lat_tab[0] = 4; lat_tab[1] = 4;
    res_tab[0] = -16'sd1; res_tab[1] = -16'sd2;
    send(5, 6, 7);
    t0 = cyc;
    wait_for(0, 200, ok);
    chk("post_tmo_seen", ok, 1);
    chk("post_tmo_latency", cyc - t0, 11);
    chk("post_tmo_pitch", pitch, -1);
    chk("post_tmo_roll", roll, -2);

    // asynchronous reset while the roll job is outstanding
    nstep();
    job_base = n_start;
    lat_tab[0] = 5; lat_tab[1] = 30;
    res_tab[0] = 16'sd500; res_tab[1] = 16'sd600;
    send(1, 1, 1);
    for (int i = 0; i < 50 && (n_start - job_base) < 2; i++) nstep();
    chk("rw_reached", n_start - job_base, 2);
    nstep();
    nstep();
    rst_n = 1'b0;
    #1;
    chk("arst_pitch", pitch, 0);
    chk("arst_roll", roll, 0);
    chk("arst_busy", busy, 0);
    chk("arst_drop", drop_cnt, 0);
    chk("arst_cx", cdra_x, 0);
    nstep();
    nstep();
    rst_n = 1'b1;
    v0 = n_valid;
    s0 = n_start;
    for (int i = 0; i < 50; i++) nstep();
    chk("arst_no_valid", n_valid - v0, 0);
    chk("arst_no_start", n_start - s0, 0);
    chk("arst_idle", busy, 0);
    chk("arst_pitch_hold", pitch, 0);

    // continuous samples against a hung CORDIC saturate the drop counter
    stub_hang = 1;
    e0 = n_err;
    sample_valid = 1'b1;
    for (int i = 0; i < 320; i++) begin
      ax = 16'(i);
      ay = 16'(i + 1);
      az = 16'(i + 2);
      nstep();
      if (i == 100) chk("sat_mid", drop_cnt, 99);
    end
    sample_valid = 1'b0;
    chk("sat_drop", drop_cnt, 255);
    chk("sat_tmo_count", n_err - e0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/attitude_angle_sched.md
Name: attitude_angle_sched

Overview:
- Sequencer that shares one cordic_angle instance between pitch and roll calculations for each accelerometer sample.
- Latches an (ax, ay, az) sample and issues two back-to-back CORDIC jobs: pitch first, then roll.
- Presents both angles together with a one-cycle valid pulse.
- Buffers one pending sample, counts dropped samples, and recovers from a hung CORDIC using a timeout.

Parameters:
- W, 16, accelerometer sample and angle width (signed).
- TIMEOUT_CYCLES, 255, maximum cycles to wait for cdra_done per job before aborting.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sample_valid  in  1  one-cycle strobe; ax/ay/az are valid this cycle
- ax  in  W  signed accel X
- ay  in  W  signed accel Y
- az  in  W  signed accel Z
- cdra_x  out  W  operand x to cordic_angle
- cdra_y  out  W  operand y to cordic_angle
- cdra_z  out  W  operand z to cordic_angle
- cdra_start  out  1  one-cycle start pulse to cordic_angle
- cdra_done  in  1  cordic_angle completion strobe
- crda_angle  in  W  cordic_angle result, valid when cdra_done=1
- pitch  out  W  last completed pitch angle
- roll  out  W  last completed roll angle
- angle_valid  out  1  one-cycle pulse when pitch and roll are updated together
- busy  out  1  high in any state other than IDLE
- err_timeout  out  1  one-cycle pulse when a job is aborted
- drop_cnt  out  DROP_W  saturating count of overwritten pending samples

Behaviour:
- Reset (asynchronous, rst_n=0): all outputs 0, state IDLE, pending slot empty, timeout counter 0. Takes effect immediately, including mid-job; a late cdra_done after reset is ignored in IDLE.
- Operand mapping:
  - Pitch job: cdra_x=ax, cdra_y=ay, cdra_z=az.
  - Roll job: cdra_x=ay, cdra_y=ax, cdra_z=az.
  - Operands come from the active-sample register and are held stable from the start pulse until cdra_done.
- FSM states: IDLE, P_START, P_WAIT, R_START, R_WAIT, PUBLISH.
  - IDLE: on sample_valid, or if the pending slot is full, load the active register (the pending slot takes priority and is then emptied; a simultaneous new sample goes into the slot) -> P_START.
  - P_START: cdra_start=1 for exactly one cycle, clear timeout counter -> P_WAIT.
  - P_WAIT: on cdra_done, capture crda_angle into a pitch temp register -> R_START. Otherwise increment the timeout counter; when it reaches TIMEOUT_CYCLES, pulse err_timeout -> IDLE with no angle update.
  - R_START: same as P_START -> R_WAIT.
  - R_WAIT: on cdra_done, capture crda_angle into a roll temp register -> PUBLISH. Timeout handled as in P_WAIT.
  - PUBLISH: pitch and roll registers update simultaneously from the temp registers; angle_valid=1 for this cycle only -> IDLE.
- Latency: angle_valid asserts 3 + Tp + Tr cycles after the accepting sample_valid edge, where Tp and Tr are the cycles from each start pulse to its cdra_done.
- cdra_start is never asserted while waiting on an outstanding job.
- cdra_done outside P_WAIT/R_WAIT is ignored.
- Pending slot:
  - sample_valid while busy with an empty slot: store the sample.
  - Slot already full: overwrite it with the new sample and increment drop_cnt, which saturates at 2^DROP_W-1 and never wraps.
  - A sample arriving in the PUBLISH cycle is treated as busy (goes to the slot).
  - Samples are never dropped in IDLE.
- pitch and roll hold their values between publishes and are never partially updated; a timeout leaves them unchanged.
- busy = (state != IDLE).

Test Plan:
- Single sample ax=10000, ay=10000, az=11585; stub CORDIC returns 1234 then -567 after 20 cycles each -> exactly two cdra_start pulses; operands (10000,10000,11585) then (10000,10000,11585); pitch=1234, roll=-567; one angle_valid pulse 43 cycles after sample_valid.
- Operand swap ax=8192, ay=-4096, az=16384 -> pitch job drives (8192,-4096,16384), roll job drives (-4096,8192,16384).
- Three sample_valid pulses during one job -> first pending sample overwritten by the third; drop_cnt=1; second angle_valid reflects the third sample.
- CORDIC stub never asserts done -> err_timeout pulses after TIMEOUT_CYCLES in P_WAIT; pitch/roll unchanged; busy=0; next sample processes normally.
- rst_n low during R_WAIT, then stub asserts cdra_done -> outputs 0, no angle_valid, no cdra_start until a new sample_valid.
- 300 overwrites with DROP_W=8 -> drop_cnt saturates at 255.
